// File: rtl/serializer_sched_pkg.sv
// Shared types and constants for the serializer frame scheduler.
package serializer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_COOL = 2'd3
    } sched_state_e;

    localparam int unsigned FRAME_BITS             = 256;
    localparam logic [3:0]  EXPECTED_SAMPLES       = 4'd8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 300;

endpackage

// File: rtl/serializer_frame_scheduler_rr_arbiter.sv
// Masked round-robin pick: search starts one past the last granted index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         mask,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] index_c,
    output logic                       any_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_elig;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;

    assign w_elig = req & ~mask;
    assign any_c  = w_found;

    // First eligible requester walking upward from r_ptr+1, wrapping to 0.
    always_comb begin
        grant_c = '0;
        index_c = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found          = 1'b1;
                index_c          = w_cand;
                grant_c[w_cand]  = 1'b1;
            end
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (advance && w_found) begin
            r_ptr <= index_c;
        end
    end

endmodule

// File: rtl/serializer_frame_scheduler.sv
// Round-robin owner of one shared serializer; sequences READY and returns DONE.
// Optional RUN watchdog abort is built when SER_SCHED_WATCHDOG_EN is defined.
module serializer_frame_scheduler
    import serializer_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         REQ,
    output logic [NUM_REQ-1:0]         GRANT,
    output logic [$clog2(NUM_REQ)-1:0] SEL,
    output logic [NUM_REQ-1:0]         DONE,
    output logic                       SER_READY,
    input  logic                       SER_COMPLETE,
    input  logic [3:0]                 SER_SAMPLE_COUNT,
    output logic                       BUSY,
    output logic                       ERROR
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    sched_state_e r_state, w_state_nxt;

    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [SEL_W-1:0]   r_sel,   w_sel_nxt;
    logic [NUM_REQ-1:0] r_done,  w_done_nxt;
    logic               r_ser_ready, w_ser_ready_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_error, w_error_nxt;

    logic [NUM_REQ-1:0] w_arb_mask;
    logic [NUM_REQ-1:0] w_arb_grant;
    logic [SEL_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic               w_arb_adv;
    logic               w_wd_expire;

    // The finishing owner sits out only the arbitration made from COOL.
    assign w_arb_mask = (r_state == ST_COOL) ? r_grant : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .CLK     (CLK),
        .RESET   (RESET),
        .req     (REQ),
        .mask    (w_arb_mask),
        .advance (w_arb_adv),
        .grant_c (w_arb_grant),
        .index_c (w_arb_idx),
        .any_c   (w_arb_any)
    );

`ifdef SER_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = 9;

    logic [WD_W-1:0] r_wd_cnt;

    // Counts completed RUN cycles; restarts with every new frame.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_wd_cnt <= '0;
        end else if (w_state_nxt == ST_LOAD) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign w_wd_expire = (r_state == ST_RUN) &&
                         (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_wd_expire = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_sel_nxt       = r_sel;
        w_done_nxt      = '0;
        w_ser_ready_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_error_nxt     = r_error;
        w_arb_adv       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_state_nxt = ST_LOAD;
                    w_grant_nxt = w_arb_grant;
                    w_sel_nxt   = w_arb_idx;
                    w_busy_nxt  = 1'b1;
                    w_arb_adv   = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                    w_sel_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end

            ST_LOAD: begin
                w_state_nxt     = ST_RUN;
                w_ser_ready_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end

            ST_RUN: begin
                w_busy_nxt = 1'b1;
                // COMPLETE wins over a coincident watchdog expiry.
                if (SER_COMPLETE) begin
                    w_state_nxt = ST_COOL;
                    w_done_nxt  = r_grant;
                    if (SER_SAMPLE_COUNT != EXPECTED_SAMPLES) begin
                        w_error_nxt = 1'b1;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_COOL;
                    w_done_nxt  = r_grant;
                    w_error_nxt = 1'b1;
                end else begin
                    w_ser_ready_nxt = 1'b1;
                end
            end

            ST_COOL: begin
                if (w_arb_any) begin
                    w_state_nxt = ST_LOAD;
                    w_grant_nxt = w_arb_grant;
                    w_sel_nxt   = w_arb_idx;
                    w_busy_nxt  = 1'b1;
                    w_arb_adv   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_sel_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_sel_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        assert (NUM_REQ >= 2 && NUM_REQ <= 8 && TIMEOUT_CYCLES >= FRAME_BITS + 4)
            else $error("serializer_frame_scheduler: illegal NUM_REQ/TIMEOUT_CYCLES");
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_sel       <= '0;
            r_done      <= '0;
            r_ser_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_sel       <= w_sel_nxt;
            r_done      <= w_done_nxt;
            r_ser_ready <= w_ser_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_error     <= w_error_nxt;
        end
    end

    assign GRANT     = r_grant;
    assign SEL       = r_sel;
    assign DONE      = r_done;
    assign SER_READY = r_ser_ready;
    assign BUSY      = r_busy;
    assign ERROR     = r_error;

endmodule
